// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: BCD typedefs and
// active-low seven-segment patterns {dp,g,f,e,d,c,b,a}.
package score_display_pkg;

    typedef logic [3:0]  bcd_digit_t;
    typedef logic [11:0] bcd_score_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_H     = 8'h89;

    // Segment patterns for BCD digits 0..9 (dp kept off).
    localparam logic [0:9][7:0] SEG_TABLE = {
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Hundreds digit of a packed BCD score.
    function automatic bcd_digit_t bcd_hundreds(input bcd_score_t s);
        return s[11:8];
    endfunction

    // Tens digit of a packed BCD score.
    function automatic bcd_digit_t bcd_tens(input bcd_score_t s);
        return s[7:4];
    endfunction

    // Ones digit of a packed BCD score.
    function automatic bcd_digit_t bcd_ones(input bcd_score_t s);
        return s[3:0];
    endfunction

endpackage

// File: rtl/score_display_bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles show a dash so corrupt data is visible rather than hidden.
module bcd_to_seg
    import score_display_pkg::*;
(
    input  bcd_digit_t  digit,
    input  logic        blank,
    output logic [7:0]  seg
);

    // Decode one nibble, honouring the blank request first.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (digit <= 4'd9) begin
            seg = SEG_TABLE[digit];
        end else begin
            seg = SEG_DASH;
        end
    end

endmodule

// File: rtl/score_display.sv
// Score display top: synchronises the BCD score from the hit-clocked
// scorer, tracks the session high score, and scans a 4-digit active-low
// seven-segment display with leading-zero blanking. While game_over is
// high the display alternates between the current and the high score.
module score_display
    import score_display_pkg::*;
#(
    parameter int SCAN_W  = 17,
    parameter int BLINK_W = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] score,
    input  logic        game_over,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic [11:0] hi_score
);

    bcd_score_t         samp1_q, samp1_d;
    bcd_score_t         samp2_q, samp2_d;
    bcd_score_t         shown_q, shown_d;
    bcd_score_t         hi_q, hi_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [7:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;

    logic [1:0]         digit_idx_s;
    logic               mode_h_s;
    bcd_score_t         src_s;
    bcd_digit_t         digit_s;
    logic               blank_s;
    logic [7:0]         dec_seg_s;

    // Two-stage capture; shown only moves when both stages agree, so a
    // word captured while the scorer was mid-update is never displayed.
    always_comb begin
        samp1_d = score;
        samp2_d = samp1_q;
        shown_d = shown_q;
        if (samp1_q == samp2_q) begin
            shown_d = samp2_q;
        end else begin
            shown_d = shown_q;
        end
    end

    // High score follows shown upward only; plain binary compare is
    // order-preserving for legal BCD.
    always_comb begin
        hi_d = hi_q;
        if (shown_q > hi_q) begin
            hi_d = shown_q;
        end else begin
            hi_d = hi_q;
        end
    end

    // Free-running scan counter and game-over blink counter.
    always_comb begin
        scan_d  = scan_q + SCAN_W'(1);
        blink_d = blink_q;
        if (game_over) begin
            blink_d = blink_q + BLINK_W'(1);
        end else begin
            blink_d = '0;
        end
    end

    assign digit_idx_s = scan_q[SCAN_W-1:SCAN_W-2];
    assign mode_h_s    = game_over & blink_q[BLINK_W-1];

    // Pick the score source and the digit to decode for this scan slot.
    always_comb begin
        src_s   = shown_q;
        digit_s = 4'd0;
        blank_s = 1'b1;
        if (mode_h_s) begin
            src_s = hi_q;
        end else begin
            src_s = shown_q;
        end
        case (digit_idx_s)
            2'd0: begin
                digit_s = bcd_ones(src_s);
                blank_s = 1'b0;
            end
            2'd1: begin
                digit_s = bcd_tens(src_s);
                blank_s = (bcd_hundreds(src_s) == 4'd0) && (bcd_tens(src_s) == 4'd0);
            end
            2'd2: begin
                digit_s = bcd_hundreds(src_s);
                blank_s = (bcd_hundreds(src_s) == 4'd0);
            end
            2'd3: begin
                digit_s = 4'd0;
                blank_s = 1'b1;
            end
            default: begin
                digit_s = 4'd0;
                blank_s = 1'b1;
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .digit (digit_s),
        .blank (blank_s),
        .seg   (dec_seg_s)
    );

    // Next segment/anode pair; both are registered together so a digit
    // enable never pairs with the previous digit's segments.
    always_comb begin
        seg_d = dec_seg_s;
        an_d  = ~(4'b0001 << digit_idx_s);
        if ((digit_idx_s == 2'd3) && mode_h_s) begin
            seg_d = SEG_H;
        end else begin
            seg_d = dec_seg_s;
        end
    end

    // State register with asynchronous reset that darkens the display at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp1_q <= 12'h000;
            samp2_q <= 12'h000;
            shown_q <= 12'h000;
            hi_q    <= 12'h000;
            scan_q  <= '0;
            blink_q <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= 4'hF;
        end else begin
            samp1_q <= samp1_d;
            samp2_q <= samp2_d;
            shown_q <= shown_d;
            hi_q    <= hi_d;
            scan_q  <= scan_d;
            blink_q <= blink_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign hi_score = hi_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with small counters (SCAN_W=4, BLINK_W=6).
// Expected display frames are queued when stimulus is applied and popped as
// the scan reaches each digit.
module tb_score_display;

    localparam int SCAN_W  = 4;
    localparam int BLINK_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] score;
    logic        game_over;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [11:0] hi_score;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [11:0] exp_q[$];

    score_display #(.SCAN_W(SCAN_W), .BLINK_W(BLINK_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .score     (score),
        .game_over (game_over),
        .seg       (seg),
        .an        (an),
        .hi_score  (hi_score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check12(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Wait for the first clock of a digit-0 slot, then compare one full frame.
    task automatic check_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
        logic [3:0] prev;
        bit found;
        exp_q.push_back({4'hE, s0});
        exp_q.push_back({4'hD, s1});
        exp_q.push_back({4'hB, s2});
        exp_q.push_back({4'h7, s3});
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (an == 4'hE && prev != 4'hE) found = 1'b1;
            else prev = an;
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL %s_sync: observed no digit-0 slot expected one within 40 clks", tag);
        end
        if (!found) begin
            exp_q.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) tick(4);
                check12($sformatf("%s_d%0d", tag, k), {an, seg}, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        logic [11:0] tv [10];
        logic [3:0]  prev_an;
        bit          found;
        int          start;

        tv = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555,
               12'h666, 12'h777, 12'h888, 12'h999, 12'h123};

        // 1. reset, then reset again mid-scan
        rst = 1'b1; score = 12'h000; game_over = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(6);
        check12("pre_rst_an", {8'h00, an}, {8'h00, 4'hD});
        rst = 1'b1;
        #1;
        check12("rst_seg", {4'h0, seg}, 12'h0FF);
        check12("rst_an", {8'h00, an}, 12'h00F);
        check12("rst_hi", hi_score, 12'h000);
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back({8'h00, ~(4'b0001 << (i / 4))});
        for (int i = 0; i < 16; i++) begin
            tick(1);
            check12($sformatf("scan_an_%0d", i), {8'h00, an}, exp_q.pop_front());
        end

        // 2. score 016
        score = 12'h016;
        tick(4);
        check_frame("s016", 8'h82, 8'hF9, 8'hFF, 8'hFF);
        check12("s016_hi", hi_score, 12'h016);

        // 3. score 100, interior zeros shown
        score = 12'h100;
        tick(4);
        check_frame("s100", 8'hC0, 8'hC0, 8'hF9, 8'hFF);
        check12("s100_hi", hi_score, 12'h100);

        // 4. score changing every clock never reaches shown
        for (int i = 0; i < 10; i++) begin
            tick(1);
            score = tv[i];
            check12($sformatf("toggle_shown_%0d", i), dut.shown_q, 12'h100);
        end
        tick(1);
        score = 12'h009;
        tick(1);
        check12("hold_shown_1", dut.shown_q, 12'h100);
        tick(1);
        check12("hold_shown_2", dut.shown_q, 12'h100);
        tick(1);
        check12("hold_shown_3", dut.shown_q, 12'h009);
        check12("toggle_hi", hi_score, 12'h100);

        // 5. fresh session: 025 then 000, then game over
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        score = 12'h025;
        tick(6);
        check12("s025_hi", hi_score, 12'h025);
        score = 12'h000;
        tick(6);
        check12("s000_hi", hi_score, 12'h025);
        game_over = 1'b1;
        start = cyc;
        check_frame("go_ph0", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        while (cyc - start < 33) tick(1);
        check_frame("go_ph1", 8'h92, 8'hA4, 8'hFF, 8'h89);
        check12("go_hi", hi_score, 12'h025);
        while (cyc - start < 97) tick(1);
        prev_an = an;
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (an == 4'hE && prev_an != 4'hE) found = 1'b1;
            else prev_an = an;
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL drop_sync: observed no digit-0 slot expected one within 40 clks");
        end
        check12("drop_before", {an, seg}, {4'hE, 8'h92});
        game_over = 1'b0;
        tick(1);
        check12("drop_after", {an, seg}, {4'hE, 8'hC0});

        // 6. non-decimal tens nibble
        score = 12'h0A3;
        tick(4);
        check_frame("s0A3", 8'hB0, 8'hBF, 8'hFF, 8'hFF);
        check12("s0A3_hi", hi_score, 12'h0A3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the 3-digit BCD score register, which is updated on the line-clear `hit` strobe.
- Samples the score safely into the system clock domain and tracks a session high score.
- Drives a 4-digit, active-low, multiplexed seven-segment display with leading-zero blanking.
- After game over, the display alternates between the current score and the high score.

Parameters:
- SCAN_W, 17: width of the scan counter. Digit index = scan_cnt[SCAN_W-1:SCAN_W-2].
- BLINK_W, 26: width of the blink counter. Show-phase = blink_cnt[BLINK_W-1].

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- score  input  12  BCD score {hundreds, tens, ones}, produced by a register clocked by `hit` (asynchronous to clk).
- game_over  input  1  level; high while the game is over.
- seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1.
- an  output  4  active-low digit enables; an[0] is the rightmost digit.
- hi_score  output  12  BCD session high score.

Behaviour:
- Reset: asynchronous, active-high; the clock is single-domain (clk). Reset applies in any state, including mid-scan, and forces:
  - seg=8'hFF, an=4'hF, hi_score=0
  - samp1=samp2=shown=0, scan_cnt=0, blink_cnt=0
- Sampling (per clk):
  - samp1<=score; samp2<=samp1.
  - If samp1==samp2, then shown<=samp2; otherwise shown holds.
  - A torn multi-bit capture is therefore never displayed.
  - Latency: a stable score change reaches shown 3 clks after it settles.
- High score:
  - Each clk, if shown > hi_score (plain 12-bit unsigned compare, valid for legal BCD), then hi_score<=shown.
  - Takes effect 1 clk after shown updates.
  - hi_score never decreases except on rst.
  - A score reset to 0 by the scorer does not clear hi_score.
- Counters:
  - scan_cnt increments every clk and wraps mod 2^SCAN_W.
  - blink_cnt increments every clk only while game_over=1; it is cleared to 0 whenever game_over=0.
- Source select:
  - src = hi_score when game_over=1 and blink_cnt MSB=1; otherwise src = shown.
  - mode_h = 1 when hi_score is selected.
- Digit selection (index d):
  - d=0: ones nibble of src, always shown (0 displays as '0').
  - d=1: tens nibble; blank if hundreds==0 and tens==0.
  - d=2: hundreds nibble; blank if hundreds==0.
  - d=3: 'H' (8'h89) if mode_h, else blank.
- Encoding (active-low), from the BCD nibble:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Nibbles A–F display '-' (8'hBF).
  - Blank = 8'hFF.
- Output timing:
  - seg and an are registered, 1 clk after d changes.
  - an = ~(4'b0001<<d).
  - seg and an always update on the same edge, so there is no ghost cycle with a mismatched digit.
- Simultaneous events:
  - A score change during blink phase 1 updates shown and hi_score internally; the new value appears in the next refreshed frame.
  - game_over falling mid-phase returns the display to shown on the next clk.
- Mid-scan reset: outputs go dark immediately (asynchronous), and scanning restarts at d=0.

Decomposition:
- Shared package holds:
  - SEG_BLANK=8'hFF, SEG_DASH=8'hBF, SEG_H=8'h89
  - the 10-entry BCD-to-segment constant table
  - the BCD digit typedef (4 bits) and BCD score typedef (12 bits)
- One natural sub-module: bcd_to_seg (combinational nibble-to-segment decoder, with a blank input). It is instantiated once, after the digit mux.

Test Plan:
All scenarios use SCAN_W=4 and BLINK_W=6.
1. Assert rst mid-scan -> seg=FF and an=F in the same cycle. After release, an sequence starts E,D,B,7, each held 4 clks.
2. score=12'h016, game_over=0 -> after ≥3 clks + 1 frame:
   - an=E shows seg=82 ('6')
   - an=D shows F9 ('1')
   - an=B shows FF (blank)
   - an=7 shows FF
   - hi_score=016
3. score=12'h100 -> digits show C0, C0, F9, FF (interior zeros not blanked).
4. score toggles to a new value every clk for 10 clks, then holds 12'h009 -> shown never takes a transitional value; shown=009 exactly 3 clks after the hold begins.
5. Sequence score=12'h025, then 12'h000, then game_over=1:
   - hi_score stays 025.
   - For blink_cnt MSB=0: display is '0' with the other digits blank.
   - After 32 clks: display shows '25' with an=7 showing 89 ('H').
   - Drop game_over -> display returns to '0' next clk.
6. score=12'h0A3 -> ones=B0, tens=BF ('-'), hundreds blank.
